// File: rtl/rgb_sram_reader.sv
// Streams the packed RGB frame out of external SRAM as 24-bit pixels (3 words -> 2 pixels).
// Latency: first pixel valid 5 cycles after the first read address (READ_LATENCY=2).
// Backpressure: Pixel_ready low stalls the unpacker; reads stop once FIFO + in-flight reach FIFO_DEPTH.
//
// Ports:
//   Clock, Reset                  system clock, asynchronous active-high reset
//   Start, Base_address           frame start pulse (accepted only when idle) and first word address
//   SRAM_address, SRAM_we_n       read address (advances only on issue), write enable tied inactive
//   SRAM_read_data                read data, valid READ_LATENCY cycles after its address
//   Pixel_R/G/B, Pixel_valid      output pixel, held stable while stalled
//   Pixel_ready                   consumer accept
//   Busy, Done                    frame in progress / one-cycle completion pulse
module rgb_sram_reader #(
  parameter int NUM_WORDS    = 115200,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic        Busy,
  output logic        Done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OC_W  = FC_W + 1;
  localparam int WC_W  = $clog2(NUM_WORDS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q,    state_d;
  logic [17:0]             addr_q,     addr_d;
  logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
  logic [READ_LATENCY-1:0] infl_q,     infl_d;
  logic [15:0]             fifo_mem_q [FIFO_DEPTH];
  logic [15:0]             fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [FC_W-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [1:0]              phase_q,    phase_d;
  logic [15:0]             hold_q,     hold_d;
  logic                    out_vld_q,  out_vld_d;
  logic [7:0]              out_r_q,    out_r_d;
  logic [7:0]              out_g_q,    out_g_d;
  logic [7:0]              out_b_q,    out_b_d;

  logic [OC_W-1:0] infl_cnt;
  logic [OC_W-1:0] outstanding;
  logic            issue;
  logic            land;
  logic            fifo_empty;
  logic            accept;
  logic            out_free;
  logic            pop;
  logic [15:0]     head;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      infl_cnt = infl_cnt + OC_W'(infl_q[i]);
    end
    // Credits cover both buffered words and reads whose data has not landed yet,
    // so landing data always finds a free FIFO slot.
    outstanding = OC_W'(fifo_cnt_q) + infl_cnt;
    issue       = (state_q == S_READ) && (outstanding < OC_W'(FIFO_DEPTH));
    land        = infl_q[READ_LATENCY-1];
    fifo_empty  = (fifo_cnt_q == '0);
    head        = fifo_mem_q[rd_ptr_q];
    accept      = out_vld_q && Pixel_ready;
    out_free    = !out_vld_q || accept;
    // Phase 0 only parks W0 in the hold register, so it never needs an output slot.
    pop         = !fifo_empty && ((phase_q == 2'd0) || out_free);
  end

  // In-flight marker: bit i set means a read issued i+1 cycles ago.
  always_comb begin
    infl_d    = '0;
    infl_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      infl_d[i] = infl_q[i-1];
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (land) begin
      fifo_mem_d[wr_ptr_q] = SRAM_read_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    fifo_cnt_d = fifo_cnt_q + FC_W'(land) - FC_W'(pop);
  end

  // Unpacker: W0={R0,G0}, W1={B0,R1}, W2={G1,B1}.
  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    out_vld_d = out_vld_q;
    out_r_d   = out_r_q;
    out_g_d   = out_g_q;
    out_b_d   = out_b_q;
    if (accept) begin
      out_vld_d = 1'b0;
    end
    if (pop) begin
      case (phase_q)
        2'd0: begin
          hold_d  = head;
          phase_d = 2'd1;
        end
        2'd1: begin
          out_r_d   = hold_q[15:8];
          out_g_d   = hold_q[7:0];
          out_b_d   = head[15:8];
          out_vld_d = 1'b1;
          hold_d    = head;
          phase_d   = 2'd2;
        end
        default: begin
          out_r_d   = hold_q[7:0];
          out_g_d   = head[15:8];
          out_b_d   = head[7:0];
          out_vld_d = 1'b1;
          phase_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_READ;
          addr_d     = Base_address;
          word_cnt_d = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d     = addr_q + 18'd1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WC_W'(NUM_WORDS - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leaving when the last pixel is accepted puts Done in the very next cycle.
        if (fifo_empty && (infl_q == '0) && (phase_q == 2'd0) && out_free) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      infl_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      phase_q    <= '0;
      hold_q     <= '0;
      out_vld_q  <= 1'b0;
      out_r_q    <= '0;
      out_g_q    <= '0;
      out_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      infl_q     <= infl_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      out_vld_q  <= out_vld_d;
      out_r_q    <= out_r_d;
      out_g_q    <= out_g_d;
      out_b_q    <= out_b_d;
    end
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Pixel_R      = out_r_q;
  assign Pixel_G      = out_g_q;
  assign Pixel_B      = out_b_q;
  assign Pixel_valid  = out_vld_q;
  assign Busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign Done         = (state_q == S_DONE);

endmodule
